// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage register and its users.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_FULL_SKID = 2'd2
    } state_t;

    // Source selected for the main (output) payload register on the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_IN     = 2'd1,
        SEL_SKID   = 2'd2,
        SEL_BUBBLE = 2'd3
    } main_sel_t;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 112;
    localparam int MEM_WB_W = 72;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy state machine for pipe_stage: handshake outputs and payload load controls.
// Handshake: a beat moves upstream when i_valid && o_ready, downstream when o_valid && i_ready.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_ready,
    input  logic       i_flush,
    output logic       o_ready,
    output logic       o_valid,
    output logic [1:0] o_state,
    output logic [1:0] o_main_sel,
    output logic       o_skid_load
);

    state_t    state_q, state_d;
    main_sel_t main_sel;
    logic      ready_q;
    logic      up_xfer;
    logic      down_xfer;

    assign o_valid   = (state_q != ST_EMPTY);
    // With the skid buffer, ready comes straight from a flop so i_ready never reaches o_ready.
    assign o_ready   = SKID ? ready_q : (!o_valid || i_ready);
    assign up_xfer   = i_valid && o_ready;
    assign down_xfer = o_valid && i_ready;

    assign o_state    = state_q;
    assign o_main_sel = main_sel;

    always_comb begin
        state_d     = state_q;
        main_sel    = SEL_HOLD;
        o_skid_load = 1'b0;
        if (i_flush) begin
            state_d  = ST_EMPTY;
            main_sel = SEL_BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state_d  = ST_FULL;
                        main_sel = SEL_IN;
                    end
                end
                ST_FULL: begin
                    if (up_xfer && down_xfer) begin
                        main_sel = SEL_IN;
                    end else if (up_xfer) begin
                        state_d     = ST_FULL_SKID;
                        o_skid_load = 1'b1;
                    end else if (down_xfer) begin
                        state_d  = ST_EMPTY;
                        main_sel = SEL_BUBBLE;
                    end
                end
                ST_FULL_SKID: begin
                    if (down_xfer) begin
                        state_d  = ST_FULL;
                        main_sel = SEL_SKID;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_sel = SEL_BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL_SKID);
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Parametrised pipeline-stage register with flush and an optional 2-entry skid buffer.
// Payload registers live here; sequencing comes from pipe_stage_ctrl.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter bit                SKID   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [1:0]        main_sel;
    logic              skid_load;
    logic [1:0]        state;

    pipe_stage_ctrl #(
        .SKID(SKID)
    ) u_ctrl (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_flush    (i_flush),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_state    (state),
        .o_main_sel (main_sel),
        .o_skid_load(skid_load)
    );

    assign o_count = state;
    assign o_data  = main_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            if (skid_load) begin
                skid_q <= i_data;
            end
            case (main_sel)
                SEL_IN:     main_q <= i_data;
                SEL_SKID:   main_q <= skid_q;
                SEL_BUBBLE: main_q <= BUBBLE;
                default:    main_q <= main_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: one SKID=1 and one SKID=0 instance share stimulus and are
// each checked against a FIFO reference of capacity 2 or 1.
module tb_pipe_stage;

  localparam int W = 16;
  localparam logic [W-1:0] BUB = 16'h0013;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         i_ready;
  logic         i_flush;
  logic         o_ready [2];
  logic         o_valid [2];
  logic [W-1:0] o_data  [2];
  logic [1:0]   o_count [2];

  logic [W-1:0] exp_q [2][$];
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pipe_stage #(.DATA_W(W), .BUBBLE(BUB), .SKID(1'b1)) dut_skid (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready[1]),
    .i_data(i_data), .o_valid(o_valid[1]), .i_ready(i_ready), .o_data(o_data[1]),
    .i_flush(i_flush), .o_count(o_count[1])
  );

  pipe_stage #(.DATA_W(W), .BUBBLE(BUB), .SKID(1'b0)) dut_pass (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready[0]),
    .i_data(i_data), .o_valid(o_valid[0]), .i_ready(i_ready), .o_data(o_data[0]),
    .i_flush(i_flush), .o_count(o_count[0])
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Driver: inputs change on negedge; the model records what the next posedge accepts.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(negedge i_clk);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    #2;
    for (int k = 0; k < 2; k++) begin
      if (f) exp_q[k].delete();
      else if (v && o_ready[k]) exp_q[k].push_back(d);
    end
  endtask

  // Monitor: compares visible state to the model and pops on each downstream transfer.
  always @(negedge i_clk) begin
    #1;
    if (!i_rst) begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        logic exp_rdy;
        logic [W-1:0] head;
        sz = exp_q[k].size();
        exp_rdy = (k == 1) ? (sz < 2) : ((sz == 0) || i_ready);
        check($sformatf("count[%0d]", k), {30'd0, o_count[k]}, sz);
        check($sformatf("valid[%0d]", k), {31'd0, o_valid[k]}, {31'd0, sz != 0});
        check($sformatf("ready[%0d]", k), {31'd0, o_ready[k]}, {31'd0, exp_rdy});
        if (sz == 0) begin
          check($sformatf("bubble[%0d]", k), {16'd0, o_data[k]}, {16'd0, BUB});
        end else if (o_valid[k] && i_ready) begin
          head = exp_q[k].pop_front();
          check($sformatf("dout[%0d]", k), {16'd0, o_data[k]}, {16'd0, head});
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_flush = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", {31'd0, o_valid[k]}, 32'd0);
      check("rst_ready", {31'd0, o_ready[k]}, 32'd1);
      check("rst_count", {30'd0, o_count[k]}, 32'd0);
      check("rst_data", {16'd0, o_data[k]}, {16'd0, BUB});
    end
    @(negedge i_clk);
    i_rst = 1'b0;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, W'(i), 1'b1, 1'b0);
    check("stream_count", {30'd0, o_count[1]}, 32'd1);
    check("stream_ready", {31'd0, o_ready[1]}, 32'd1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall with skid fill, then drain.
    drive_cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'hBBBB, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    check("stall_count", {30'd0, o_count[1]}, 32'd2);
    check("stall_ready", {31'd0, o_ready[1]}, 32'd0);
    check("stall_data", {16'd0, o_data[1]}, 32'h0000AAAA);
    check("pass_stall_ready", {31'd0, o_ready[0]}, 32'd0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_ready", {31'd0, o_ready[1]}, 32'd1);

    // Flush colliding with both transfers.
    drive_cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'hCCCC, 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check("flush_valid", {31'd0, o_valid[1]}, 32'd0);
    check("flush_data", {16'd0, o_data[1]}, {16'd0, BUB});
    drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Combinational ready on the pass-through instance.
    drive_cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    check("pass_ready_low", {31'd0, o_ready[0]}, 32'd0);
    drive_cycle(1'b1, 16'h6666, 1'b1, 1'b0);
    check("pass_ready_high", {31'd0, o_ready[0]}, 32'd1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check("pass_new_beat", {16'd0, o_data[0]}, 32'h00006666);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while the skid instance holds two entries.
    drive_cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h8888, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, o_valid[1]}, 32'd0);
    check("mid_rst_ready", {31'd0, o_ready[1]}, 32'd1);
    check("mid_rst_count", {30'd0, o_count[1]}, 32'd0);
    check("mid_rst_data", {16'd0, o_data[1]}, {16'd0, BUB});
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge i_clk);
    i_rst = 1'b0;

    // Randomised traffic against the reference FIFOs.
    for (int n = 0; n < 10000; n++) begin
      drive_cycle($urandom_range(0, 99) < 70, W'($urandom_range(0, 16'hFFFF)),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Parametrised pipeline-stage register, the successor to the fixed PC/instruction latch between pipeline stages.
- Carries an arbitrary-width payload under a valid/ready handshake, with stall (backpressure), flush (kill to bubble) and an optional 2-entry skid buffer so o_ready is fully registered.
- Instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with a per-stage payload width.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {pc, instruction} for IF/ID).
- BUBBLE, {DATA_W{1'b0}}, payload driven on o_data when the stage is empty after reset or flush (IF/ID uses {32'h0, 32'h00000013}).
- SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational ready pass-through.

Ports:
- i_clk, input, 1, clock; all state updates on posedge.
- i_rst, input, 1, asynchronous active-high reset.
- i_valid, input, 1, upstream payload valid.
- o_ready, output, 1, stage can accept; transfer when i_valid && o_ready.
- i_data, input, DATA_W, upstream payload.
- o_valid, output, 1, downstream payload valid.
- i_ready, input, 1, downstream accepts; transfer when o_valid && i_ready.
- o_data, output, DATA_W, downstream payload.
- i_flush, input, 1, synchronous kill of all held entries.
- o_count, output, 2, number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Reset (async, immediate while i_rst=1): o_valid=0, o_data=BUBBLE, skid empty, o_count=0, o_ready=1. Upstream must hold i_valid=0 during reset. Reset mid-transfer discards all held data; nothing is replayed.
- Latency: 1 cycle from upstream transfer to o_valid when empty. Throughput: 1 transfer/cycle in both modes while i_ready=1.
- SKID=1 states (state = o_count):
  - EMPTY(0):
    - up-xfer -> FULL, main <= i_data.
  - FULL(1):
    - up-xfer && down-xfer -> FULL, main <= i_data.
    - up-xfer && !i_ready -> FULL_SKID, skid <= i_data.
    - down-xfer only -> EMPTY, main <= BUBBLE.
  - FULL_SKID(2):
    - o_ready=0.
    - down-xfer -> FULL, main <= skid.
    - otherwise hold.
  - o_ready = (state != FULL_SKID), taken from a flop; no combinational path from i_ready.
- SKID=0: o_ready = !o_valid || i_ready (combinational). States EMPTY/FULL only.
- Ordering: strict FIFO. Skid data is never overtaken by i_data.
- Flush: when i_flush=1 at a posedge, all entries are cleared next cycle (o_valid=0, o_data=BUBBLE, o_count=0). A simultaneous up-xfer is accepted by handshake but discarded. A simultaneous down-xfer still completes (the downstream consumed it that cycle). Flush beats every other transition.
- Payload is held stable while o_valid && !i_ready (stall). o_data changes only on down-xfer, up-xfer into EMPTY, flush, or reset.
- No width arithmetic. o_count saturates by construction; asserting i_valid while o_ready=0 has no effect.

Decomposition:
- Package pipe_pkg:
  - state enum {ST_EMPTY=2'd0, ST_FULL=2'd1, ST_FULL_SKID=2'd2}.
  - constant RV_NOP=32'h00000013.
  - per-stage payload width constants.
- One sub-module, pipe_stage_ctrl: state machine, o_ready/o_valid, main/skid load enables. Not parametrised on DATA_W.
- Top level holds the payload registers and the mux (i_data / skid / BUBBLE).

Test Plan:
- Reset: i_rst=1 mid-stream with o_count=2 -> same cycle o_valid=0, o_data=BUBBLE, o_ready=1, o_count=0.
- Streaming: SKID=1, i_ready=1, i_data=1,2,3,4 on consecutive cycles -> o_data 1,2,3,4 one cycle later, o_ready stays 1, o_count=1 throughout.
- Stall: i_ready=0 after accepting A, then B offered -> o_count=2, o_ready=0, o_data=A held. Release i_ready -> A then B out, no loss or duplication, o_ready returns to 1 the cycle after the skid drains.
- Flush with collision: o_count=2, i_flush=1 with i_ready=1 and i_valid=1 (C) -> next cycle o_valid=0, o_data=BUBBLE, C never appears.
- SKID=0: i_ready=0 with o_valid=1 -> o_ready=0 in the same cycle. Raise i_ready -> o_ready=1 combinationally and a new beat is accepted in that cycle.
- Random: 10k cycles of random i_valid, i_ready and i_flush (5%) against a reference queue model -> output order and values match; no data escapes flush.
